// File: rtl/program_memory_pkg.sv
// Shared definitions for the program memory: instruction opcodes, register ids,
// the fill word used for cleared / out-of-range entries, and the clear FSM states.
package program_memory_pkg;

   localparam int unsigned OPC_W     = 4;
   localparam int unsigned OPERAND_W = 24;
   localparam int unsigned REG_W     = 4;

   typedef enum logic [OPC_W-1:0] {
      OP_NOP  = 4'h0,
      OP_LOAD = 4'h1,
      OP_ADD  = 4'h2,
      OP_SUB  = 4'h3,
      OP_JMP  = 4'h4,
      OP_LED  = 4'h5,
      OP_HALT = 4'hF
   } opcode_e;

   localparam logic [REG_W-1:0] REG_R0 = 4'h0;
   localparam logic [REG_W-1:0] REG_R1 = 4'h1;
   localparam logic [REG_W-1:0] REG_R2 = 4'h2;
   localparam logic [REG_W-1:0] REG_R3 = 4'h3;

   typedef struct packed {
      opcode_e              opcode;
      logic [OPERAND_W-1:0] operand;
   } instr_t;

   // LED instruction with an alternating bit pattern: easy to spot on a board
   localparam instr_t DEFAULT_INSTR = '{opcode: OP_LED, operand: 24'b10101010};

   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } init_state_e;

endpackage

// File: rtl/prog_mem_init_seq.sv
// Post-reset clear sequencer: walks every storage entry once, one per cycle,
// then raises done and stays in S_RUN until the next reset.
module prog_mem_init_seq
   import program_memory_pkg::*;
#(
   parameter  int unsigned DEPTH = 256,
   localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   output logic             wr_o,
   output logic [CNT_W-1:0] addr_o,
   output logic             done_o
);

   init_state_e      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             wr_q;
   logic             done_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
         wr_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_INIT: begin
               if (cnt_q == CNT_W'(DEPTH - 1)) begin
                  state_q <= S_RUN;
                  wr_q    <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_RUN: begin
               state_q <= S_RUN;
            end
            default: begin
               state_q <= S_INIT;
            end
         endcase
      end
   end

   assign wr_o   = wr_q;
   assign addr_o = cnt_q;
   assign done_o = done_q;

endmodule

// File: rtl/program_memory.sv
// Instruction store with a self-clearing init phase, a load (write) port and a
// registered read port with write-first forwarding and out-of-range flagging.
module program_memory
   import program_memory_pkg::*;
#(
   parameter int unsigned          DATA_WIDTH   = 28,
   parameter int unsigned          ADDR_WIDTH   = 16,
   parameter int unsigned          DEPTH        = 256,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = DATA_WIDTH'(DEFAULT_INSTR)
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  iReadEnable,
   input  logic [ADDR_WIDTH-1:0] iAddress,
   output logic [DATA_WIDTH-1:0] oInstruction,
   output logic                  oValid,
   output logic                  oReady,
   output logic                  oAddrError,
   input  logic                  iLoadEnable,
   input  logic [ADDR_WIDTH-1:0] iLoadAddress,
   input  logic [DATA_WIDTH-1:0] iLoadData
);

   localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

   logic             init_wr;
   logic [IDX_W-1:0] init_addr;
   logic             init_done;

   prog_mem_init_seq #(
      .DEPTH (DEPTH)
   ) u_init_seq (
      .clk_i  (Clock),
      .rst_i  (Reset),
      .wr_o   (init_wr),
      .addr_o (init_addr),
      .done_o (init_done)
   );

   logic                  rd_oob_c;
   logic                  ld_oob_c;
   logic                  rd_acc_c;
   logic                  ld_acc_c;
   logic                  fwd_c;
   logic                  wr_en_c;
   logic [IDX_W-1:0]      wr_idx_c;
   logic [DATA_WIDTH-1:0] wr_data_c;
   logic [DATA_WIDTH-1:0] rd_data_c;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   assign rd_oob_c = ({1'b0, iAddress} >= DEPTH_L);
   assign ld_oob_c = ({1'b0, iLoadAddress} >= DEPTH_L);
   assign rd_acc_c = init_done & iReadEnable;
   assign ld_acc_c = init_done & iLoadEnable;
   assign fwd_c    = ld_acc_c & ~ld_oob_c & (iLoadAddress == iAddress);

   // Write port: the clear sequencer owns the port until it is done
   always_comb begin
      wr_en_c   = 1'b0;
      wr_idx_c  = init_addr;
      wr_data_c = DEFAULT_WORD;
      if (init_wr) begin
         wr_en_c = 1'b1;
      end else if (ld_acc_c && !ld_oob_c) begin
         wr_en_c   = 1'b1;
         wr_idx_c  = iLoadAddress[IDX_W-1:0];
         wr_data_c = iLoadData;
      end
   end

   always_ff @(posedge Clock) begin
      if (wr_en_c) begin
         mem_q[wr_idx_c] <= wr_data_c;
      end
   end

   // The array read sees the pre-write value, so a same-address load is forwarded
   always_comb begin
      rd_data_c = mem_q[iAddress[IDX_W-1:0]];
      if (rd_oob_c) begin
         rd_data_c = DEFAULT_WORD;
      end else if (fwd_c) begin
         rd_data_c = iLoadData;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         oInstruction <= DEFAULT_WORD;
         oValid       <= 1'b0;
         oAddrError   <= 1'b0;
      end else begin
         oValid <= rd_acc_c;
         if (rd_acc_c) begin
            oInstruction <= rd_data_c;
         end
         if (rd_acc_c || ld_acc_c) begin
            oAddrError <= (rd_acc_c & rd_oob_c) | (ld_acc_c & ld_oob_c);
         end
      end
   end

   assign oReady = init_done;

endmodule
